fp_cmp_scheduler: RTL and testbench
===================================

Name: fp_cmp_scheduler

Overview:
- Time-shares one pipelined FloPoCo 11/17 floating-point subtract-and-compare datapath among N_REQ requesters, e.g. the per-axis slab-test units of the ray/AABB engine.
- Accepts compare requests (A >= B?) over per-requester valid/ready handshakes and grants them round-robin.
- Tags each issued request and carries the tags alongside the subtractor pipeline.
- Returns the greater-or-equal flag, a NaN flag and the requester's ID to the originating requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 30, MSB index of the FloPoCo word (word is WIDTH+1 = 31 bits: exc[30:29], sign[28], exp[27:17], frac[16:0]).
- SUB_LAT, 2, pipeline depth of the FPSub_11_17_F400_uid2 instance in cycles.
- ID_W, 4, width of the opaque request ID returned with the result.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  N_REQ  request present, one bit per requester
- req_ready  out  N_REQ  grant/accept, one-hot or zero
- req_a  in  N_REQ*(WIDTH+1)  operand A, requester i at slice i
- req_b  in  N_REQ*(WIDTH+1)  operand B, requester i at slice i
- req_id  in  N_REQ*ID_W  request ID, requester i at slice i
- res_valid  out  N_REQ  one-cycle result pulse, one-hot to the owning requester
- res_ge  out  1  1 when A >= B
- res_nan  out  1  1 when the subtract result is NaN
- res_id  out  ID_W  ID of the request whose result is on the bus
- busy  out  1  any request in flight

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: res_valid=0, res_ge=0, res_nan=0, res_id=0, busy=0, RR pointer=0, all tag-pipe valids cleared.
- Arbitration:
  - Combinational round robin starting at pointer p.
  - req_ready[i]=1 for the first i (from p, modulo N_REQ) with req_valid[i]=1.
  - At most one grant per cycle; no grant if no request.
  - Accept = valid & ready. After accepting i, p <= (i+1) mod N_REQ. With no accept, p holds.
- Requester rules: a, b and id stay stable while valid is high until accepted. Dropping valid before acceptance is allowed and no result is generated.
- Issue: the granted a/b drive the shared subtractor X/Y in the accept cycle. Non-accept cycles drive the last value; the output is ignored.
- Tag pipe:
  - SUB_LAT+1 stages of {valid, requester index, id}.
  - Stage 0 loads at accept.
  - Final stage aligns with the registered classification.
- Classification (registered one cycle after R emerges), on R = A - B:
  - exc=00 (zero): ge=1, nan=0.
  - exc=01 (normal): ge=~sign, nan=0.
  - exc=10 (infinity): ge=~sign, nan=0.
  - exc=11 (NaN): ge=0, nan=1.
- Latency: fixed LAT = SUB_LAT+1 cycles from the accept edge to the res_valid pulse. Throughput is one request per cycle.
- Result bus: res_valid is a single-cycle pulse with no backpressure; the requester must sink it. res_ge/res_nan/res_id are held between pulses.
- busy = OR of all tag-pipe valid bits.
- Reset mid-operation: all in-flight tags are discarded. No res_valid until a new accept completes LAT cycles later. Stale subtractor contents never surface.
- Back-to-back requests from the same requester are legal; results return in issue order.
- Simultaneous accept and result in the same cycle are independent.

Decomposition:
- Shared package:
  - FloPoCo field-position constants (EXC_HI=30, EXC_LO=29, SIGN=28).
  - Exception codes (EXC_ZERO=2'b00, EXC_NORM=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11).
  - Tag width helper TAG_W = clog2(N_REQ).
- Sub-module rr_arbiter (N parameter):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Reused by the future multi-unit min/max schedulers.
- The FPSub instance and the classification register stay in the top.

Test Plan:
- Single request, requester 0: a={01,0,0x400,0} (2.0), b={01,0,0x3FF,0} (1.0), id=5 accepted at cycle t -> res_valid=0001, res_ge=1, res_nan=0, res_id=5 at t+3.
- Equal operands a=b=1.0 -> res_ge=1 (zero result). Reversed a=1.0, b=2.0 -> res_ge=0.
- a={11,0,0,0} (NaN), b=1.0 -> res_ge=0, res_nan=1.
- All four req_valid held high for 8 cycles with p=0 -> grant order 0,1,2,3,0,1,2,3; res_valid one-hot in the same order, each 3 cycles after its accept, IDs matched.
- Requester 2 asserts valid while requester 1 was last granted -> ready[2] next.
- Requester 2 drops valid un-accepted -> no result, p unchanged.
- Issue 3 requests, assert rst for 1 cycle at t+1 -> res_valid stays 0 and busy=0 from reset onward. A new request accepted after release returns exactly 3 cycles later.

Source files
------------

// File: rtl/fp_cmp_scheduler_pkg.sv
// rtl/fp_cmp_scheduler_pkg.sv - FloPoCo field positions, exception codes and tag width helper
package fp_cmp_scheduler_pkg;

    localparam int EXC_HI = 30;
    localparam int EXC_LO = 29;
    localparam int SIGN   = 28;

    typedef enum logic [1:0] {
        EXC_ZERO = 2'b00,
        EXC_NORM = 2'b01,
        EXC_INF  = 2'b10,
        EXC_NAN  = 2'b11
    } exc_e;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/FPSub_11_17_F400_uid2.sv
// rtl/FPSub_11_17_F400_uid2.sv - two-stage X-Y core; exception and sign of R are exact, exp/frac fields are zero
module FPSub_11_17_F400_uid2
    import fp_cmp_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic [30:0] X,
    input  logic [30:0] Y,
    output logic [30:0] R
);

    logic [30:0] r_x;
    logic [30:0] r_y;
    logic [30:0] r_r;
    exc_e        w_ex;
    exc_e        w_ey;
    exc_e        w_exc;
    logic        w_sx;
    logic        w_sny;
    logic        w_sign;

    assign w_ex  = exc_e'(r_x[EXC_HI:EXC_LO]);
    assign w_ey  = exc_e'(r_y[EXC_HI:EXC_LO]);
    assign w_sx  = r_x[SIGN];
    assign w_sny = ~r_y[SIGN];

    // X - Y is evaluated as X + (-Y); w_sny is the sign of the negated subtrahend
    always_comb begin
        w_exc  = EXC_NORM;
        w_sign = w_sx;
        if (w_ex == EXC_NAN || w_ey == EXC_NAN) begin
            w_exc  = EXC_NAN;
            w_sign = 1'b0;
        end else if (w_ex == EXC_INF && w_ey == EXC_INF) begin
            w_exc  = (w_sx == w_sny) ? EXC_INF : EXC_NAN;
            w_sign = (w_sx == w_sny) ? w_sx : 1'b0;
        end else if (w_ex == EXC_INF) begin
            w_exc  = EXC_INF;
        end else if (w_ey == EXC_INF) begin
            w_exc  = EXC_INF;
            w_sign = w_sny;
        end else if (w_ex == EXC_ZERO && w_ey == EXC_ZERO) begin
            w_exc  = EXC_ZERO;
            w_sign = w_sx & w_sny;
        end else if (w_ex == EXC_ZERO) begin
            w_sign = w_sny;
        end else if (w_ey == EXC_ZERO || w_sx == w_sny) begin
            w_sign = w_sx;
        end else if (r_x[SIGN-1:0] == r_y[SIGN-1:0]) begin
            w_exc  = EXC_ZERO;
            w_sign = 1'b0;
        end else begin
            w_sign = (r_x[SIGN-1:0] > r_y[SIGN-1:0]) ? w_sx : w_sny;
        end
    end

    always_ff @(posedge clk) begin
        r_x <= X;
        r_y <= Y;
        r_r <= {w_exc, w_sign, 28'd0};
    end

    assign R = r_r;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter.sv - combinational round-robin arbiter: first request at or after the pointer wins
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    int w_slot;

    // Scan farthest-from-pointer first so the nearest request overwrites earlier hits
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_slot = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_slot = (int'(i_ptr) + k) % N;
            if (i_req[w_slot]) begin
                o_gnt         = '0;
                o_gnt[w_slot] = 1'b1;
                o_idx         = IW'(w_slot);
            end
        end
    end

endmodule

// File: rtl/fp_cmp_scheduler.sv
// rtl/fp_cmp_scheduler.sv - round-robin time-sharing of one pipelined FP subtract/compare among N_REQ requesters
module fp_cmp_scheduler
    import fp_cmp_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 30,
    parameter int SUB_LAT = 2,
    parameter int ID_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*(WIDTH+1)-1:0]   req_a,
    input  logic [N_REQ*(WIDTH+1)-1:0]   req_b,
    input  logic [N_REQ*ID_W-1:0]        req_id,
    output logic [N_REQ-1:0]             res_valid,
    output logic                         res_ge,
    output logic                         res_nan,
    output logic [ID_W-1:0]              res_id,
    output logic                         busy
);

    localparam int W     = WIDTH + 1;
    localparam int TAG_W = tag_width(N_REQ);

    logic [N_REQ-1:0] w_gnt;
    logic [TAG_W-1:0] w_gnt_idx;
    logic             w_accept;
    logic [TAG_W-1:0] r_ptr;
    logic [W-1:0]     w_x;
    logic [W-1:0]     w_y;
    logic [ID_W-1:0]  w_id;
    logic [W-1:0]     r_x_hold;
    logic [W-1:0]     r_y_hold;
    logic [W-1:0]     w_r;
    logic [SIGN-1:0]  w_unused_mag;
    logic             w_ge;
    logic             w_nan;
    logic             r_ge;
    logic             r_nan;
    logic [ID_W-1:0]  r_res_id;

    logic             r_tag_v   [0:SUB_LAT];
    logic [TAG_W-1:0] r_tag_idx [0:SUB_LAT];
    logic [ID_W-1:0]  r_tag_id  [0:SUB_LAT];

    rr_arbiter #(
        .N  (N_REQ),
        .IW (TAG_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // Idle cycles replay the last operands; their results are never tagged
    always_comb begin
        w_x  = r_x_hold;
        w_y  = r_y_hold;
        w_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_x  = req_a[i*W +: W];
                w_y  = req_b[i*W +: W];
                w_id = req_id[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_x_hold <= '0;
            r_y_hold <= '0;
        end else begin
            r_x_hold <= w_x;
            r_y_hold <= w_y;
            if (w_accept) begin
                r_ptr <= (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= SUB_LAT; k++) begin
                r_tag_v[k]   <= 1'b0;
                r_tag_idx[k] <= '0;
                r_tag_id[k]  <= '0;
            end
        end else begin
            r_tag_v[0]   <= w_accept;
            r_tag_idx[0] <= w_gnt_idx;
            r_tag_id[0]  <= w_id;
            for (int k = 1; k <= SUB_LAT; k++) begin
                r_tag_v[k]   <= r_tag_v[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    FPSub_11_17_F400_uid2 u_sub (
        .clk (clk),
        .X   (w_x),
        .Y   (w_y),
        .R   (w_r)
    );

    assign w_unused_mag = w_r[SIGN-1:0];

    always_comb begin
        w_ge  = 1'b0;
        w_nan = 1'b0;
        unique case (exc_e'(w_r[EXC_HI:EXC_LO]))
            EXC_ZERO: w_ge  = 1'b1;
            EXC_NORM: w_ge  = ~w_r[SIGN];
            EXC_INF:  w_ge  = ~w_r[SIGN];
            EXC_NAN:  w_nan = 1'b1;
        endcase
    end

    // Loads only when a tagged result emerges, so the bus holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ge     <= 1'b0;
            r_nan    <= 1'b0;
            r_res_id <= '0;
        end else if (r_tag_v[SUB_LAT-1]) begin
            r_ge     <= w_ge;
            r_nan    <= w_nan;
            r_res_id <= r_tag_id[SUB_LAT-1];
        end
    end

    always_comb begin
        res_valid = '0;
        if (r_tag_v[SUB_LAT]) begin
            res_valid[r_tag_idx[SUB_LAT]] = 1'b1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= SUB_LAT; k++) begin
            busy = busy | r_tag_v[k];
        end
    end

    assign res_ge  = r_ge;
    assign res_nan = r_nan;
    assign res_id  = r_res_id;

endmodule

// File: tb/tb_fp_cmp_scheduler.sv
// tb/tb_fp_cmp_scheduler.sv - self-checking bench for fp_cmp_scheduler
module tb_fp_cmp_scheduler;

    localparam int N    = 4;
    localparam int W    = 31;
    localparam int ID_W = 4;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [N*ID_W-1:0] req_id;
    logic [N-1:0]      res_valid;
    logic              res_ge;
    logic              res_nan;
    logic [ID_W-1:0]   res_id;
    logic              busy;

    fp_cmp_scheduler #(.N_REQ(N), .WIDTH(30), .SUB_LAT(2), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_id    (req_id),
        .res_valid (res_valid),
        .res_ge    (res_ge),
        .res_nan   (res_nan),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: compare by real value ordering; zero sign is irrelevant, inf beyond every finite
    function automatic longint fval(input logic [W-1:0] x);
        longint m;
        case (x[30:29])
            2'b00:   m = 0;
            2'b01:   m = (longint'(1) << 28) + longint'(x[27:0]);
            default: m = longint'(1) << 29;
        endcase
        return x[28] ? -m : m;
    endfunction

    function automatic logic ref_nan(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a[30:29] == 2'b11) || (b[30:29] == 2'b11) ||
               (a[30:29] == 2'b10 && b[30:29] == 2'b10 && a[28] == b[28]);
    endfunction

    function automatic logic ref_ge(input logic [W-1:0] a, input logic [W-1:0] b);
        return !ref_nan(a, b) && (fval(a) >= fval(b));
    endfunction

    function automatic logic [N-1:0] ref_grant(input logic [N-1:0] v, input int p);
        logic [N-1:0] g = '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) begin
                g[(p + k) % N] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        int r;
        logic [1:0] e;
        logic [10:0] ex;
        logic [16:0] fr;
        r  = $urandom_range(0, 9);
        e  = (r < 6) ? 2'b01 : (r == 6) ? 2'b00 : (r == 7) ? 2'b10 : (r == 8) ? 2'b11 : 2'b01;
        ex = 11'h3FE + 11'($urandom_range(0, 3));
        fr = ($urandom_range(0, 1) != 0) ? 17'h0 : 17'($urandom_range(0, 3));
        return {e, 1'($urandom_range(0, 1)), ex, fr};
    endfunction

    typedef struct {
        int              due;
        int              idx;
        logic [ID_W-1:0] id;
        logic            ge;
        logic            nan;
    } exp_t;

    exp_t            q[$];
    int              mp;
    logic [N-1:0]    acc_vec = '0;
    logic            last_ge = 1'b0;
    logic            last_nan = 1'b0;
    logic [ID_W-1:0] last_id = '0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mp       = 0;
            acc_vec  = '0;
            last_ge  = 1'b0;
            last_nan = 1'b0;
            last_id  = '0;
            chk("rst_res_valid", 64'(res_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end else begin
            exp_t e;
            chk("busy", 64'(busy), 64'(q.size() != 0));
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("res_valid", 64'(res_valid), 64'(1) << e.idx);
                chk("res_ge", 64'(res_ge), 64'(e.ge));
                chk("res_nan", 64'(res_nan), 64'(e.nan));
                chk("res_id", 64'(res_id), 64'(e.id));
                last_ge  = e.ge;
                last_nan = e.nan;
                last_id  = e.id;
            end else begin
                chk("res_idle", 64'(res_valid), 64'(0));
                chk("hold_ge", 64'(res_ge), 64'(last_ge));
                chk("hold_id", 64'(res_id), 64'(last_id));
            end
            chk("ready", 64'(req_ready), 64'(ref_grant(req_valid, mp)));
            acc_vec = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i]) begin
                    e.due = cyc + LAT;
                    e.idx = i;
                    e.id  = req_id[i*ID_W +: ID_W];
                    e.ge  = ref_ge(req_a[i*W +: W], req_b[i*W +: W]);
                    e.nan = ref_nan(req_a[i*W +: W], req_b[i*W +: W]);
                    q.push_back(e);
                    mp = (i + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [ID_W-1:0] id);
        req_a[i*W +: W]       = a;
        req_b[i*W +: W]       = b;
        req_id[i*ID_W +: ID_W] = id;
    endtask

    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [ID_W-1:0] id;
        logic            ge;
        logic            nan;
    } vec_t;

    localparam logic [W-1:0] ONE     = {2'b01, 1'b0, 11'h3FF, 17'h0};
    localparam logic [W-1:0] TWO     = {2'b01, 1'b0, 11'h400, 17'h0};
    localparam logic [W-1:0] NEG_ONE = {2'b01, 1'b1, 11'h3FF, 17'h0};
    localparam logic [W-1:0] NEG_TWO = {2'b01, 1'b1, 11'h400, 17'h0};
    localparam logic [W-1:0] QNAN    = {2'b11, 29'h0};
    localparam logic [W-1:0] PINF    = {2'b10, 1'b0, 28'h0};
    localparam logic [W-1:0] NINF    = {2'b10, 1'b1, 28'h0};
    localparam logic [W-1:0] ZERO    = {2'b00, 29'h0};

    vec_t tbl[9];
    int   c;

    initial begin
        tbl[0] = '{TWO,     ONE,     4'd5,  1'b1, 1'b0};
        tbl[1] = '{ONE,     ONE,     4'd6,  1'b1, 1'b0};
        tbl[2] = '{ONE,     TWO,     4'd7,  1'b0, 1'b0};
        tbl[3] = '{QNAN,    ONE,     4'd8,  1'b0, 1'b1};
        tbl[4] = '{PINF,    TWO,     4'd9,  1'b1, 1'b0};
        tbl[5] = '{NINF,    TWO,     4'd10, 1'b0, 1'b0};
        tbl[6] = '{PINF,    PINF,    4'd11, 1'b0, 1'b1};
        tbl[7] = '{ZERO,    NEG_ONE, 4'd12, 1'b1, 1'b0};
        tbl[8] = '{NEG_TWO, NEG_ONE, 4'd13, 1'b0, 1'b0};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_res_id", 64'(res_id), 64'(0));
        chk("reset_res_ge", 64'(res_ge), 64'(0));
        chk("reset_res_nan", 64'(res_nan), 64'(0));
        tick();
        rst = 1'b0;

        foreach (tbl[v]) begin
            tick();
            set_req(0, tbl[v].a, tbl[v].b, tbl[v].id);
            req_valid = 4'b0001;
            @(negedge clk);
            chk("tbl_ready", 64'(req_ready), 64'(4'b0001));
            c = cyc;
            tick();
            req_valid = '0;
            while (cyc < c + LAT) @(negedge clk);
            chk("tbl_valid", 64'(res_valid), 64'(4'b0001));
            chk("tbl_ge", 64'(res_ge), 64'(tbl[v].ge));
            chk("tbl_nan", 64'(res_nan), 64'(tbl[v].nan));
            chk("tbl_id", 64'(res_id), 64'(tbl[v].id));
        end

        tick();
        for (int i = 0; i < 3; i++) set_req(i, rnd_op(), rnd_op(), 4'(8 + i));
        req_valid = 4'b0111;
        repeat (3) begin
            tick();
            req_valid &= ~acc_vec;
        end
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_valid", 64'(res_valid), 64'(0));
            chk("postrst_busy", 64'(busy), 64'(0));
        end
        tick();
        set_req(3, TWO, ONE, 4'hC);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("postrst_ready", 64'(req_ready), 64'(4'b1000));
        c = cyc;
        tick();
        req_valid = '0;
        while (cyc < c + LAT) @(negedge clk);
        chk("postrst_res", 64'(res_valid), 64'(4'b1000));
        chk("postrst_id", 64'(res_id), 64'(4'hC));

        tick();
        for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op(), 4'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_order", 64'(req_ready), 64'(1) << (k % N));
            tick();
            for (int i = 0; i < N; i++)
                if (acc_vec[i]) set_req(i, rnd_op(), rnd_op(), 4'(k + i + 1));
        end
        req_valid = '0;
        repeat (4) tick();

        set_req(1, ONE, TWO, 4'h1);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("rr_one", 64'(req_ready), 64'(4'b0010));
        tick();
        set_req(0, TWO, ONE, 4'h2);
        set_req(2, ONE, ONE, 4'h3);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rr_after1", 64'(req_ready), 64'(4'b0100));
        tick();
        set_req(2, QNAN, ONE, 4'h4);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("rr_wrap", 64'(req_ready), 64'(4'b0001));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("drop_none", 64'(req_ready), 64'(0));
        tick();
        set_req(1, TWO, TWO, 4'h5);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("drop_ptr_held", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        repeat (4) tick();

        repeat (400) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc_vec[i]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 6) begin
                    req_valid[i] = 1'b1;
                    set_req(i, rnd_op(), rnd_op(), 4'($urandom_range(0, 15)));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        tick();
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        chk("final_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
